// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// pc_sequencer : fetch PC owner, next-PC select (branch/jump/hold/seq),
// pipeline flush control and redirect debug counters.       Rev 1.0
// ============================================================================
module pc_sequencer #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          CNT_W    = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             stall_i,
   input  logic             branch_i,
   input  logic             take_i,
   input  logic [31:0]      branch_offset_i,
   input  logic [31:0]      branch_pc4_i,
   input  logic             jump_i,
   input  logic [25:0]      jump_index_i,
   input  logic [31:0]      jump_pc4_i,
   output logic [31:0]      pc_o,
   output logic [31:0]      pc_plus4_o,
   output logic             flush_ifid_o,
   output logic             flush_idex_o,
   output logic             flush_exmem_o,
   output logic [1:0]       cause_o,
   output logic [CNT_W-1:0] redirect_cnt_o
);

   localparam logic [1:0]       c_CAUSE_NONE   = 2'd0;
   localparam logic [1:0]       c_CAUSE_BRANCH = 2'd1;
   localparam logic [1:0]       c_CAUSE_JUMP   = 2'd2;
   localparam logic [CNT_W-1:0] c_CNT_ONE      = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [31:0]      r_pc;
   logic [31:0]      r_pc4;
   logic [1:0]       r_cause;
   logic [CNT_W-1:0] r_cnt;

   logic             w_branch;
   logic             w_jump;
   logic             w_redirect;
   logic [31:0]      w_br_tgt;
   logic [31:0]      w_j_tgt;
   logic [31:0]      w_next_pc;
   logic [31:0]      w_next_pc4;
   logic             w_unused;

   // A taken branch in MEM squashes everything younger, including an ID jump.
   assign w_branch   = branch_i & take_i;
   assign w_jump     = jump_i & ~w_branch;
   assign w_redirect = w_branch | w_jump;

   assign w_br_tgt = branch_pc4_i + {branch_offset_i[29:0], 2'b00};
   assign w_j_tgt  = {jump_pc4_i[31:28], jump_index_i, 2'b00};

   // Offset bits above the shift and low jump_pc4 bits do not reach a target.
   assign w_unused = ^{branch_offset_i[31:30], jump_pc4_i[27:0]};

   always_comb begin
      w_next_pc  = r_pc4;
      w_next_pc4 = r_pc4 + 32'd4;
      if (w_branch) begin
         w_next_pc  = w_br_tgt;
         w_next_pc4 = w_br_tgt + 32'd4;
      end else if (w_jump) begin
         w_next_pc  = w_j_tgt;
         w_next_pc4 = w_j_tgt + 32'd4;
      end else if (stall_i) begin
         w_next_pc  = r_pc;
         w_next_pc4 = r_pc4;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_pc    <= RESET_PC;
         r_pc4   <= RESET_PC + 32'd4;
         r_cause <= c_CAUSE_NONE;
         r_cnt   <= '0;
      end else begin
         r_pc  <= w_next_pc;
         r_pc4 <= w_next_pc4;
         if (w_branch) begin
            r_cause <= c_CAUSE_BRANCH;
         end else if (w_jump) begin
            r_cause <= c_CAUSE_JUMP;
         end
         if (w_redirect && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + c_CNT_ONE;
         end
      end
   end

   // Flushes are gated by reset so they stay low while reset is held.
   assign flush_ifid_o   = rst_i & w_redirect;
   assign flush_idex_o   = rst_i & w_branch;
   assign flush_exmem_o  = rst_i & w_branch;

   assign pc_o           = r_pc;
   assign pc_plus4_o     = r_pc4;
   assign cause_o        = r_cause;
   assign redirect_cnt_o = r_cnt;

endmodule
`default_nettype wire

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Owns the program counter of the 5-stage pipelined CPU and selects its next value each cycle: sequential, taken branch, jump, or hold.
- Sequences the branch-offset datapath: branch target = PC+4 of the branch plus the sign-extended offset shifted left two.
- Drives the IF/ID, ID/EX and EX/MEM flush controls on a redirect.
- Keeps a saturating redirect counter and a last-redirect-cause register for debug.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
CNT_W, 16, width of the redirect counter.

Ports:
clk_i  input  1  clock; all state updates on rising edge
rst_i  input  1  asynchronous active-low reset
stall_i  input  1  load-use stall from the hazard unit; hold PC
branch_i  input  1  branch instruction valid in MEM stage
take_i  input  1  branch condition true (qualified by branch_i)
branch_offset_i  input  32  sign-extended 16-bit immediate of the MEM-stage branch
branch_pc4_i  input  32  PC+4 of the MEM-stage branch
jump_i  input  1  j/jal decoded in ID stage
jump_index_i  input  26  instr[25:0] of the ID-stage jump
jump_pc4_i  input  32  PC+4 of the ID-stage jump
pc_o  output  32  current fetch PC (registered)
pc_plus4_o  output  32  pc_o + 4 (registered, not recomputed combinationally)
flush_ifid_o  output  1  clear IF/ID at next edge
flush_idex_o  output  1  clear ID/EX at next edge
flush_exmem_o  output  1  clear EX/MEM at next edge
cause_o  output  2  last redirect cause: 0 none, 1 branch, 2 jump
redirect_cnt_o  output  CNT_W  number of redirects, saturating

Behaviour:
- Reset (rst_i low, asynchronous, any cycle including mid-redirect):
  - pc_o = RESET_PC; pc_plus4_o = RESET_PC+4.
  - cause_o = 0; redirect_cnt_o = 0.
  - All flush outputs 0, forced regardless of other inputs while reset is held.
- Arithmetic, modulo 2^32, carries discarded:
  - br_tgt = branch_pc4_i + {branch_offset_i[29:0], 2'b00}.
  - j_tgt = {jump_pc4_i[31:28], jump_index_i, 2'b00}.
- Next-PC priority, evaluated combinationally, applied at the rising edge:
  1. BRANCH: branch_i & take_i. PC <= br_tgt.
     - flush_ifid_o, flush_idex_o and flush_exmem_o all 1 in this same cycle.
     - stall_i and jump_i are ignored, because those instructions are wrong-path.
  2. JUMP: jump_i & ~(branch_i & take_i). PC <= j_tgt.
     - flush_ifid_o = 1; other flushes 0.
     - Overrides stall_i: the jump sits in ID and is not held by a load-use stall of the following instruction.
  3. HOLD: stall_i with no redirect. PC and pc_plus4 unchanged; no flush.
  4. SEQ: PC <= pc_plus4_o.
- A not-taken branch (branch_i & ~take_i) behaves as SEQ/HOLD; no flush, no count.
- pc_plus4_o always equals pc_o+4 one cycle later, i.e. it is registered together with PC.
- Flush outputs are combinational and last exactly one cycle per redirect event. Back-to-back redirects assert them on consecutive cycles.
- cause_o updates only on BRANCH (1) or JUMP (2) and holds otherwise.
- redirect_cnt_o increments by 1 on each BRANCH or JUMP edge and saturates at 2^CNT_W-1 (no wrap).
- No other internal state.

Test Plan:
- Reset, then 3 free-running cycles -> pc_o = 0x0, 0x4, 0x8, 0xC; flushes 0; redirect_cnt_o = 0.
- Backward branch: branch_pc4_i = 0x10, branch_offset_i = 0xFFFFFFFE, take_i = 1 -> next pc_o = 0x08; all three flushes high for one cycle; cause_o = 1; count = 1.
- Jump with jump_pc4_i = 0x8000_0014, jump_index_i = 0x0000040 -> pc_o = 0x8000_0100; only flush_ifid_o high; cause_o = 2. Same jump with stall_i = 1 -> still redirects.
- Branch taken, jump_i = 1 and stall_i = 1 in the same cycle -> br_tgt wins; three flushes; count +1 only.
- stall_i high for 2 cycles at pc_o = 0x20 -> pc_o stays 0x20 with pc_plus4_o = 0x24; then resumes at 0x24. Not-taken branch -> no flush, count unchanged.
- Wrap and saturation: branch_pc4_i = 0xFFFF_FFFC, offset = 2 -> pc_o = 0x0000_0004. With CNT_W = 2, 5 redirects -> redirect_cnt_o = 3. Drop rst_i mid-cycle -> pc_o = RESET_PC immediately, without waiting for a clock edge.
